// File: rtl/n_bit_serial_subtractor.sv
// Bit-serial N-bit subtractor: res = a - b - bin, one bit per clock, LSB first.
// The minuend register doubles as the difference register: each shifted-in bit replaces a consumed one.
module n_bit_serial_subtractor #(
  parameter int N = 7
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         bin_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [N:0]   res_o
);

  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]    r_state;
  logic [N-1:0]  r_a;
  logic [N-1:0]  r_b;
  logic          r_br;
  logic [CW-1:0] r_cnt;
  logic [N:0]    r_res;

  logic          w_a0;
  logic          w_b0;
  logic          w_d;
  logic          w_br_next;
  logic          w_last;
  logic [N-1:0]  w_a_next;

  assign w_a0      = r_a[0];
  assign w_b0      = r_b[0];
  assign w_d       = w_a0 ^ w_b0 ^ r_br;
  assign w_br_next = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & r_br);
  assign w_last    = (r_cnt == CW'(N - 1));

  // Difference bit enters at the MSB as the consumed minuend bit leaves at the LSB.
  generate
    if (N == 1) begin : g_single
      assign w_a_next = w_d;
    end else begin : g_multi
      assign w_a_next = {w_d, r_a[N-1:1]};
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      r_res   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_a     <= a_i;
            r_b     <= b_i;
            r_br    <= bin_i;
            r_cnt   <= '0;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_a   <= w_a_next;
          r_b   <= r_b >> 1;
          r_br  <= w_br_next;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_res   <= {w_br_next, w_a_next};
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o = (r_state == S_SHIFT);
  assign done_o = (r_state == S_DONE);
  assign res_o  = r_res;

endmodule

// File: tb/tb_n_bit_serial_subtractor.sv
// Self-checking bench for n_bit_serial_subtractor against an arithmetic reference model.
module tb_n_bit_serial_subtractor;

  localparam int N = 7;

  logic         clk_i;
  logic         rst_ni;
  logic         start_i;
  logic [N-1:0] a_i;
  logic [N-1:0] b_i;
  logic         bin_i;
  logic         busy_o;
  logic         done_o;
  logic [N:0]   res_o;

  int n_checks;
  int n_errors;
  logic [N:0] last_res;

  n_bit_serial_subtractor #(.N(N)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .start_i (start_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .bin_i   (bin_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .res_o   (res_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Reference: plain signed arithmetic, truncated to N+1 bits.
  function automatic logic [N:0] ref_sub(input int a, input int b, input int bin);
    int v;
    v = a - b - bin;
    return v[N:0];
  endfunction

  // Drives one operation starting immediately (caller ensures DUT is idle, just after an edge).
  // When inject is set, start pulses with junk operands during SHIFT and DONE.
  task automatic run_op(input int a, input int b, input int bin, input bit inject, input string tag);
    logic [N:0] exp;
    exp = ref_sub(a, b, bin);
    start_i = 1'b1;
    a_i     = a[N-1:0];
    b_i     = b[N-1:0];
    bin_i   = bin[0];
    @(posedge clk_i); #1;
    start_i = 1'b0;
    a_i     = N'($urandom);
    b_i     = N'($urandom);
    bin_i   = 1'($urandom);
    n_checks++;
    if (busy_o !== 1'b1 || done_o !== 1'b0) begin
      n_errors++;
      $display("FAIL %s busy_start: busy=%b done=%b required busy=1 done=0", tag, busy_o, done_o);
    end
    for (int i = 1; i < N; i++) begin
      if (inject && i == 2) start_i = 1'b1;
      if (inject && i == 3) start_i = 1'b0;
      @(posedge clk_i); #1;
      n_checks++;
      if (busy_o !== 1'b1 || done_o !== 1'b0 || res_o !== last_res) begin
        n_errors++;
        $display("FAIL %s shift_cycle%0d: busy=%b done=%b res=%h required busy=1 done=0 res=%h",
                 tag, i, busy_o, done_o, res_o, last_res);
      end
    end
    start_i = 1'b0;
    @(posedge clk_i); #1;
    n_checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b0 || res_o !== exp) begin
      n_errors++;
      $display("FAIL %s done: done=%b busy=%b res=%h required done=1 busy=0 res=%h",
               tag, done_o, busy_o, res_o, exp);
    end
    if (inject) begin
      start_i = 1'b1;
      a_i     = N'($urandom);
      b_i     = N'($urandom);
    end
    @(posedge clk_i); #1;
    n_checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b0 || res_o !== exp) begin
      n_errors++;
      $display("FAIL %s idle_after: done=%b busy=%b res=%h required done=0 busy=0 res=%h",
               tag, done_o, busy_o, res_o, exp);
    end
    start_i = 1'b0;
    last_res = exp;
    $display("op %s: a=%0d b=%0d bin=%0d res=%h expected=%h", tag, a, b, bin, res_o, exp);
  endtask

  task automatic test_reset();
    #2 rst_ni = 1'b0;
    #1;
    n_checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || res_o !== '0) begin
      n_errors++;
      $display("FAIL reset_initial: busy=%b done=%b res=%h required 0 0 0", busy_o, done_o, res_o);
    end
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    n_checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || res_o !== '0) begin
      n_errors++;
      $display("FAIL reset_released_idle: busy=%b done=%b res=%h required 0 0 0", busy_o, done_o, res_o);
    end
    last_res = '0;
    $display("reset: busy=%b done=%b res=%h", busy_o, done_o, res_o);
  endtask

  task automatic test_directed();
    run_op(100, 37, 0, 1'b0, "positive");
    run_op(5, 9, 1, 1'b0, "negative");
    n_checks++;
    if (res_o[N] !== 1'b1) begin
      n_errors++;
      $display("FAIL negative_borrow: res[N]=%b required 1", res_o[N]);
    end
  endtask

  task automatic test_back_to_back();
    run_op(0, 127, 1, 1'b0, "extreme_min");
    run_op(127, 0, 0, 1'b0, "extreme_max");
    run_op(0, 0, 0, 1'b0, "zero");
  endtask

  task automatic test_start_ignored();
    run_op(42, 17, 1, 1'b1, "ignored_start");
    @(posedge clk_i); #1;
    n_checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || res_o !== last_res) begin
      n_errors++;
      $display("FAIL ignored_hold: busy=%b done=%b res=%h required 0 0 %h", busy_o, done_o, res_o, last_res);
    end
    run_op(3, 90, 0, 1'b0, "after_ignored");
  endtask

  task automatic test_random();
    int a, b, bin;
    for (int t = 0; t < 24; t++) begin
      a   = int'($urandom_range(0, (1 << N) - 1));
      b   = int'($urandom_range(0, (1 << N) - 1));
      bin = int'($urandom_range(0, 1));
      run_op(a, b, bin, (t % 5) == 4, "random");
    end
  endtask

  task automatic test_reset_mid_op();
    start_i = 1'b1;
    a_i     = N'(77);
    b_i     = N'(11);
    bin_i   = 1'b0;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    @(posedge clk_i);
    @(posedge clk_i);
    @(posedge clk_i); #2;
    rst_ni = 1'b0;
    #1;
    n_checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || res_o !== '0) begin
      n_errors++;
      $display("FAIL reset_mid_op: busy=%b done=%b res=%h required 0 0 0", busy_o, done_o, res_o);
    end
    for (int i = 0; i < N + 2; i++) begin
      @(posedge clk_i); #1;
      n_checks++;
      if (done_o !== 1'b0 || busy_o !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_hold%0d: busy=%b done=%b required 0 0", i, busy_o, done_o);
      end
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    last_res = '0;
    $display("reset_mid_op: busy=%b done=%b res=%h", busy_o, done_o, res_o);
    run_op(1, 1, 0, 1'b0, "post_reset");
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_ni   = 1'b1;
    start_i  = 1'b0;
    a_i      = '0;
    b_i      = '0;
    bin_i    = 1'b0;
    last_res = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_start_ignored();
    test_random();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
